lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 21 ++
 rtl/lsu.sv | 194 +++++++++++++++++++
 tb/tb_lsu.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Request/response bus between the core pipeline and the load/store unit.
interface lsu_if;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic        i_lsu_wren;
  logic        i_lsu_rden;
  logic [2:0]  i_lsu_op;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_misaligned;

  modport master (
    output i_lsu_addr, i_st_data, i_lsu_wren, i_lsu_rden, i_lsu_op,
    input  o_ld_data, o_ld_valid, o_misaligned
  );

  modport slave (
    input  i_lsu_addr, i_st_data, i_lsu_wren, i_lsu_rden, i_lsu_op,
    output o_ld_data, o_ld_valid, o_misaligned
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: byte-addressable DMEM, memory-mapped LED/HEX/LCD output registers
// and synchronised switch/button inputs, with a registered one-cycle load path.
module lsu #(
  parameter int unsigned DMEM_BYTES = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst,
  lsu_if.slave        bus,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_hex_lo,
  output logic [31:0] o_io_hex_hi,
  output logic [31:0] o_io_lcd
);

  localparam int unsigned AW    = $clog2(DMEM_BYTES);
  localparam int unsigned WORDS = DMEM_BYTES / 4;

  localparam logic [31:0] ADDR_LEDR   = 32'h0000_7000;
  localparam logic [31:0] ADDR_LEDG   = 32'h0000_7010;
  localparam logic [31:0] ADDR_HEX_LO = 32'h0000_7020;
  localparam logic [31:0] ADDR_HEX_HI = 32'h0000_7024;
  localparam logic [31:0] ADDR_LCD    = 32'h0000_7030;
  localparam logic [31:0] ADDR_SW     = 32'h0000_7800;
  localparam logic [31:0] ADDR_BTN    = 32'h0000_7810;
  localparam logic [31:0] DMEM_LIMIT  = 32'(DMEM_BYTES);

  function automatic logic [3:0] lane_mask(input logic is_b, input logic is_h,
                                           input logic [1:0] off);
    logic [3:0] m;
    if (is_b)      m = 4'b0001 << off;
    else if (is_h) m = off[1] ? 4'b1100 : 4'b0011;
    else           m = 4'b1111;
    return m;
  endfunction

  // Replicate the store operand so every enabled lane sees its own bytes.
  function automatic logic [31:0] lane_data(input logic is_b, input logic is_h,
                                            input logic [31:0] d);
    logic [31:0] r;
    if (is_b)      r = {4{d[7:0]}};
    else if (is_h) r = {2{d[15:0]}};
    else           r = d;
    return r;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? wd[8*k +: 8] : old[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic is_b, input logic is_h, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    if (is_b)      r = uns ? {24'h0, b} : {{24{b[7]}}, b};
    else if (is_h) r = uns ? {16'h0, h} : {{16{h[15]}}, h};
    else           r = w;
    return r;
  endfunction

  logic [31:0] addr;
  logic        is_b, is_h, is_w, is_uns, mis;
  logic        hit_dmem, hit_ledr, hit_ledg, hit_hex_lo, hit_hex_hi, hit_lcd, hit_sw, hit_btn;
  logic        st_en, ld_en, mis_pulse;
  logic [3:0]  be;
  logic [31:0] wdata, rd_word;
  logic [AW-3:0] dm_idx;

  logic [31:0] dmem [WORDS];

  logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d, hex_lo_q, hex_lo_d;
  logic [31:0] hex_hi_q, hex_hi_d, lcd_q, lcd_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_valid_q, ld_valid_d, mis_q, mis_d;
  logic [31:0] sw_s1_q, sw_s2_q;
  logic [3:0]  btn_s1_q, btn_s2_q;

  assign addr = bus.i_lsu_addr;

  // Undefined encodings (011, 110, 111) fall through to word access.
  always_comb begin
    is_b   = (bus.i_lsu_op == 3'b000) || (bus.i_lsu_op == 3'b100);
    is_h   = (bus.i_lsu_op == 3'b001) || (bus.i_lsu_op == 3'b101);
    is_w   = !is_b && !is_h;
    is_uns = bus.i_lsu_op[2] && !is_w;
    mis    = (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
  end

  always_comb begin
    hit_dmem   = addr < DMEM_LIMIT;
    hit_ledr   = addr[31:2] == ADDR_LEDR[31:2];
    hit_ledg   = addr[31:2] == ADDR_LEDG[31:2];
    hit_hex_lo = addr[31:2] == ADDR_HEX_LO[31:2];
    hit_hex_hi = addr[31:2] == ADDR_HEX_HI[31:2];
    hit_lcd    = addr[31:2] == ADDR_LCD[31:2];
    hit_sw     = addr[31:2] == ADDR_SW[31:2];
    hit_btn    = addr[31:2] == ADDR_BTN[31:2];
  end

  // A simultaneous store wins over the load; misaligned stores never write.
  always_comb begin
    st_en     = bus.i_lsu_wren && !i_rst && !mis;
    ld_en     = bus.i_lsu_rden && !bus.i_lsu_wren && !i_rst;
    mis_pulse = (bus.i_lsu_wren || bus.i_lsu_rden) && mis && !i_rst;
    be        = lane_mask(is_b, is_h, addr[1:0]);
    wdata     = lane_data(is_b, is_h, bus.i_st_data);
    dm_idx    = addr[AW-1:2];
  end

  always_ff @(posedge i_clk) begin
    if (st_en && hit_dmem) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) dmem[dm_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (hit_dmem)        rd_word = dmem[dm_idx];
    else if (hit_ledr)   rd_word = ledr_q;
    else if (hit_ledg)   rd_word = ledg_q;
    else if (hit_hex_lo) rd_word = hex_lo_q;
    else if (hit_hex_hi) rd_word = hex_hi_q;
    else if (hit_lcd)    rd_word = lcd_q;
    else if (hit_sw)     rd_word = sw_s2_q;
    else if (hit_btn)    rd_word = {28'h0, btn_s2_q};
  end

  always_comb begin
    ledr_d   = (st_en && hit_ledr)   ? merge_lanes(ledr_q,   wdata, be) : ledr_q;
    ledg_d   = (st_en && hit_ledg)   ? merge_lanes(ledg_q,   wdata, be) : ledg_q;
    hex_lo_d = (st_en && hit_hex_lo) ? merge_lanes(hex_lo_q, wdata, be) : hex_lo_q;
    hex_hi_d = (st_en && hit_hex_hi) ? merge_lanes(hex_hi_q, wdata, be) : hex_hi_q;
    lcd_d    = (st_en && hit_lcd)    ? merge_lanes(lcd_q,    wdata, be) : lcd_q;
  end

  // Unmapped reads see rd_word = 0, so only misalignment needs forcing to zero.
  always_comb begin
    ld_valid_d = ld_en;
    mis_d      = mis_pulse;
    ld_data_d  = ld_data_q;
    if (ld_en) ld_data_d = mis ? '0 : extract(rd_word, addr[1:0], is_b, is_h, is_uns);
  end

  // Request stage -> response stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ledr_q     <= '0;
      ledg_q     <= '0;
      hex_lo_q   <= '0;
      hex_hi_q   <= '0;
      lcd_q      <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
    end else begin
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      hex_lo_q   <= hex_lo_d;
      hex_hi_q   <= hex_hi_d;
      lcd_q      <= lcd_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      mis_q      <= mis_d;
      sw_s1_q    <= i_io_sw;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= i_io_btn;
      btn_s2_q   <= btn_s1_q;
    end
  end

  assign bus.o_ld_data    = ld_data_q;
  assign bus.o_ld_valid   = ld_valid_q;
  assign bus.o_misaligned = mis_q;
  assign o_io_ledr        = ledr_q;
  assign o_io_ledg        = ledg_q;
  assign o_io_hex_lo      = hex_lo_q;
  assign o_io_hex_hi      = hex_hi_q;
  assign o_io_lcd         = lcd_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, hand-written multi-cycle sequences, and
// randomized traffic checked against a byte-level memory-map model.
module tb_lsu;
  localparam int unsigned DMEM_BYTES = 2048;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_io_sw;
  logic [3:0]  i_io_btn;
  logic [31:0] o_io_ledr, o_io_ledg, o_io_hex_lo, o_io_hex_hi, o_io_lcd;

  lsu_if bus ();

  lsu #(.DMEM_BYTES(DMEM_BYTES)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus         (bus),
    .i_io_sw     (i_io_sw),
    .i_io_btn    (i_io_btn),
    .o_io_ledr   (o_io_ledr),
    .o_io_ledg   (o_io_ledg),
    .o_io_hex_lo (o_io_hex_lo),
    .o_io_hex_hi (o_io_hex_hi),
    .o_io_lcd    (o_io_lcd)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] d;
    logic        ev;
    logic        em;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [7:0]  m_mem [DMEM_BYTES];
  logic [31:0] m_reg [5];
  int          since_rst;
  logic [31:0] sw_val;
  logic [3:0]  btn_val;

  logic [31:0] reg_addrs [7] = '{32'h7000, 32'h7010, 32'h7020, 32'h7024, 32'h7030,
                                 32'h7800, 32'h7810};
  logic [31:0] unmapped  [6] = '{32'h0001_7000, 32'h8000_0100, 32'h0000_7004,
                                 32'h0000_4000, 32'h0000_7814, 32'hFFFF_7000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic we, input logic re, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] d);
    i_rst          = rst;
    bus.i_lsu_wren = we;
    bus.i_lsu_rden = re;
    bus.i_lsu_op   = op;
    bus.i_lsu_addr = addr;
    bus.i_st_data  = d;
    @(posedge i_clk);
    #1;
    i_rst          = 1'b0;
    bus.i_lsu_wren = 1'b0;
    bus.i_lsu_rden = 1'b0;
  endtask

  task automatic add(input string name, input logic we, input logic re, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] d,
                     input logic ev, input logic em, input logic [31:0] ed);
    vec_t v;
    v.name = name; v.we = we; v.re = re; v.op = op; v.addr = addr; v.d = d;
    v.ev = ev; v.em = em; v.ed = ed;
    vecs.push_back(v);
  endtask

  function automatic int size_of(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd4) return 1;
    if (op == 3'd1 || op == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int reg_index(input logic [31:0] a);
    case (a & 32'hFFFF_FFFC)
      32'h7000: return 0;
      32'h7010: return 1;
      32'h7020: return 2;
      32'h7024: return 3;
      32'h7030: return 4;
      32'h7800: return 5;
      32'h7810: return 6;
      default:  return -1;
    endcase
  endfunction

  function automatic logic [7:0] model_byte(input logic [31:0] a);
    int r;
    logic [31:0] w;
    if (a < DMEM_BYTES) return m_mem[a];
    r = reg_index(a);
    case (r)
      0, 1, 2, 3, 4: w = m_reg[r];
      5:             w = (since_rst >= 2) ? sw_val : 32'h0;
      6:             w = (since_rst >= 2) ? {28'h0, btn_val} : 32'h0;
      default:       w = 32'h0;
    endcase
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input logic uns);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(model_byte(a + 32'(i))) << (8*i));
    if (!uns && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!uns && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      logic [31:0] ba;
      logic [7:0]  by;
      int          r;
      ba = a + 32'(i);
      by = d[8*i +: 8];
      r  = reg_index(ba);
      if (ba < DMEM_BYTES) m_mem[ba] = by;
      else if (r >= 0 && r <= 4) m_reg[r][8*ba[1:0] +: 8] = by;
    end
  endtask

  function automatic logic [31:0] pick_addr();
    int cls = $urandom_range(0, 9);
    logic [31:0] a;
    case (cls)
      0, 1, 2: a = 32'h300 + 32'($urandom_range(0, 31));
      3:       a = 32'($urandom_range(0, DMEM_BYTES - 1));
      4:       a = 32'(DMEM_BYTES - 4 + $urandom_range(0, 7));
      5, 6, 7: a = reg_addrs[$urandom_range(0, 6)] + 32'($urandom_range(0, 3));
      default: a = unmapped[$urandom_range(0, 5)] + 32'($urandom_range(0, 3));
    endcase
    return a;
  endfunction

  initial begin : main
    logic        r_rst, r_we, r_re, r_mis, r_ev, r_em, r_uns;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_d, r_ed;
    int          r_n;

    i_io_sw = 32'h0;
    i_io_btn = 4'h0;
    bus.i_lsu_addr = 32'h0;
    bus.i_st_data = 32'h0;
    bus.i_lsu_op = 3'b010;
    bus.i_lsu_wren = 1'b0;
    bus.i_lsu_rden = 1'b0;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ld_data", bus.o_ld_data, 32'h0);
    chk("rst_ld_valid", {31'h0, bus.o_ld_valid}, 32'h0);
    chk("rst_misaligned", {31'h0, bus.o_misaligned}, 32'h0);
    chk("rst_ledr", o_io_ledr, 32'h0);
    chk("rst_lcd", o_io_lcd, 32'h0);
    i_rst = 1'b0;

    //   name        we re op      addr          data           ev em  expected data
    add("sw_100",    1, 0, 3'b010, 32'h100,  32'hDEADBEEF, 0, 0, 32'h0);
    add("lw_100",    0, 1, 3'b010, 32'h100,  32'h0,        1, 0, 32'hDEADBEEF);
    add("sb_103",    1, 0, 3'b000, 32'h103,  32'h00000080, 0, 0, 32'h0);
    add("lb_103",    0, 1, 3'b000, 32'h103,  32'h0,        1, 0, 32'hFFFFFF80);
    add("lbu_103",   0, 1, 3'b100, 32'h103,  32'h0,        1, 0, 32'h00000080);
    add("lw_100b",   0, 1, 3'b010, 32'h100,  32'h0,        1, 0, 32'h80ADBEEF);
    add("lh_102",    0, 1, 3'b001, 32'h102,  32'h0,        1, 0, 32'hFFFF80AD);
    add("lhu_102",   0, 1, 3'b101, 32'h102,  32'h0,        1, 0, 32'h000080AD);
    add("lb_100",    0, 1, 3'b000, 32'h100,  32'h0,        1, 0, 32'hFFFFFFEF);
    add("lbu_101",   0, 1, 3'b100, 32'h101,  32'h0,        1, 0, 32'h000000BE);
    add("lh_101mis", 0, 1, 3'b001, 32'h101,  32'h0,        1, 1, 32'h0);
    add("sw_102mis", 1, 0, 3'b010, 32'h102,  32'h11111111, 0, 1, 32'h0);
    add("lw_100c",   0, 1, 3'b010, 32'h100,  32'h0,        1, 0, 32'h80ADBEEF);
    add("op011_lw",  0, 1, 3'b011, 32'h100,  32'h0,        1, 0, 32'h80ADBEEF);
    add("op110_lw",  0, 1, 3'b110, 32'h100,  32'h0,        1, 0, 32'h80ADBEEF);
    add("op111_mis", 0, 1, 3'b111, 32'h101,  32'h0,        1, 1, 32'h0);
    add("lw_unmap",  0, 1, 3'b010, 32'h4000, 32'h0,        1, 0, 32'h0);
    add("collide",   1, 1, 3'b010, 32'h200,  32'h5A5A5A5A, 0, 0, 32'h0);
    add("lw_200",    0, 1, 3'b010, 32'h200,  32'h0,        1, 0, 32'h5A5A5A5A);
    add("idle",      0, 0, 3'b010, 32'h200,  32'h0,        0, 0, 32'h0);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].we, vecs[i].re, vecs[i].op, vecs[i].addr, vecs[i].d);
      chk({vecs[i].name, "_valid"}, {31'h0, bus.o_ld_valid}, {31'h0, vecs[i].ev});
      chk({vecs[i].name, "_mis"}, {31'h0, bus.o_misaligned}, {31'h0, vecs[i].em});
      if (vecs[i].ev) chk({vecs[i].name, "_data"}, bus.o_ld_data, vecs[i].ed);
    end

    // Output registers with lane writes
    step(1'b0, 1'b1, 1'b0, 3'b010, 32'h7000, 32'h12345678);
    chk("ledr_sw", o_io_ledr, 32'h12345678);
    step(1'b0, 1'b1, 1'b0, 3'b001, 32'h7002, 32'h0000ABCD);
    chk("ledr_sh", o_io_ledr, 32'hABCD5678);
    step(1'b0, 1'b0, 1'b1, 3'b010, 32'h7000, 32'h0);
    chk("ledr_lw", bus.o_ld_data, 32'hABCD5678);
    step(1'b0, 1'b1, 1'b0, 3'b000, 32'h7011, 32'h0000005A);
    chk("ledg_sb", o_io_ledg, 32'h00005A00);
    step(1'b0, 1'b1, 1'b0, 3'b010, 32'h7020, 32'h11111111);
    step(1'b0, 1'b1, 1'b0, 3'b010, 32'h7024, 32'h22222222);
    step(1'b0, 1'b1, 1'b0, 3'b010, 32'h7030, 32'h33333333);
    chk("hex_lo_sw", o_io_hex_lo, 32'h11111111);
    chk("hex_hi_sw", o_io_hex_hi, 32'h22222222);
    chk("lcd_sw", o_io_lcd, 32'h33333333);

    // Store presented during reset is discarded; registers clear
    step(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h00000001);
    chk("rstc_ledr", o_io_ledr, 32'h0);
    chk("rstc_ledg", o_io_ledg, 32'h0);
    chk("rstc_hex_lo", o_io_hex_lo, 32'h0);
    chk("rstc_hex_hi", o_io_hex_hi, 32'h0);
    chk("rstc_lcd", o_io_lcd, 32'h0);
    chk("rstc_ld_data", bus.o_ld_data, 32'h0);
    step(1'b0, 1'b0, 1'b1, 3'b010, 32'h200, 32'h0);
    chk("post_rst_lw_valid", {31'h0, bus.o_ld_valid}, 32'h1);
    chk("post_rst_lw_200", bus.o_ld_data, 32'h5A5A5A5A);

    // Switch synchroniser latency and read-only behaviour
    i_io_sw = 32'h55;
    step(1'b0, 1'b0, 1'b1, 3'b010, 32'h7800, 32'h0);
    chk("sw_sync_n", bus.o_ld_data, 32'h0);
    step(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 3'b010, 32'h7800, 32'h0);
    chk("sw_sync_n2", bus.o_ld_data, 32'h55);
    step(1'b0, 1'b1, 1'b0, 3'b010, 32'h7800, 32'hFFFFFFFF);
    step(1'b0, 1'b0, 1'b1, 3'b010, 32'h7800, 32'h0);
    chk("sw_readonly", bus.o_ld_data, 32'h55);
    i_io_btn = 4'hA;
    step(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 3'b010, 32'h7810, 32'h0);
    chk("btn_read", bus.o_ld_data, 32'h0000000A);

    // Randomized traffic against the model, starting from reset and a full DMEM fill
    sw_val   = $urandom;
    btn_val  = 4'($urandom_range(0, 15));
    i_io_sw  = sw_val;
    i_io_btn = btn_val;
    step(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) m_reg[k] = 32'h0;
    since_rst = 0;
    for (int w = 0; w < DMEM_BYTES / 4; w++) begin
      r_d = $urandom;
      step(1'b0, 1'b1, 1'b0, 3'b010, 32'(w * 4), r_d);
      model_store(32'(w * 4), 4, r_d);
      since_rst++;
    end

    for (int c = 0; c < 800; c++) begin
      r_rst = ($urandom_range(0, 49) == 0);
      r_we  = ($urandom_range(0, 2) == 0);
      r_re  = 1'($urandom_range(0, 1));
      r_op  = 3'($urandom_range(0, 7));
      r_a   = pick_addr();
      r_d   = $urandom;
      r_n   = size_of(r_op);
      r_uns = (r_op == 3'd4) || (r_op == 3'd5);
      r_mis = (r_a % r_n) != 0;
      r_ev  = r_re && !r_we && !r_rst;
      r_em  = (r_we || r_re) && r_mis && !r_rst;
      r_ed  = (r_ev && !r_mis) ? model_load(r_a, r_n, r_uns) : 32'h0;
      step(r_rst, r_we, r_re, r_op, r_a, r_d);
      if (r_rst) begin
        for (int k = 0; k < 5; k++) m_reg[k] = 32'h0;
        since_rst = 0;
        chk("rnd_rst_data", bus.o_ld_data, 32'h0);
      end else begin
        if (r_we && !r_mis) model_store(r_a, r_n, r_d);
        since_rst++;
      end
      chk("rnd_valid", {31'h0, bus.o_ld_valid}, {31'h0, r_ev});
      chk("rnd_mis", {31'h0, bus.o_misaligned}, {31'h0, r_em});
      if (r_ev) chk("rnd_data", bus.o_ld_data, r_ed);
      chk("rnd_ledr", o_io_ledr, m_reg[0]);
      chk("rnd_ledg", o_io_ledg, m_reg[1]);
      chk("rnd_hex_lo", o_io_hex_lo, m_reg[2]);
      chk("rnd_hex_hi", o_io_hex_hi, m_reg[3]);
      chk("rnd_lcd", o_io_lcd, m_reg[4]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
